// File: rtl/conv_window_sched.sv
// Raster-frame scheduler for the KxK convolution window datapath: counts accepted
// pixels, drives the line-buffer shift and hands complete windows to the MAC array.
module conv_window_sched #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K     = 3,
  parameter int CW    = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_pix_valid,
  output logic          o_pix_ready,
  output logic          o_lb_en,
  output logic          o_win_valid,
  input  logic          i_win_ready,
  output logic [CW-1:0] o_win_col,
  output logic [CW-1:0] o_win_row,
  output logic          o_busy,
  output logic          o_frame_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [CW-1:0] KM1      = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [CW-1:0] row;

  logic accept;
  logic consume;
  logic win_load;
  logic col_wrap;
  logic last_pix;

  // Ready looks through a window being consumed this cycle so the pipe never bubbles.
  always_comb begin
    o_pix_ready = (state == S_RUN) && (!o_win_valid || i_win_ready);
    accept      = i_pix_valid && o_pix_ready;
    consume     = o_win_valid && i_win_ready;
    col_wrap    = (col == COL_LAST);
    win_load    = accept && (col >= KM1) && (row >= KM1);
    last_pix    = accept && col_wrap && (row == ROW_LAST);
  end

  assign o_lb_en = accept;
  assign o_busy  = (state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      col          <= '0;
      row          <= '0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_RUN;
            col   <= '0;
            row   <= '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (col_wrap) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pix) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!o_win_valid || consume) begin
            o_frame_done <= 1'b1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A newly completed window takes priority over clearing the one being consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_win_valid <= 1'b0;
      o_win_col   <= '0;
      o_win_row   <= '0;
    end else if (state == S_IDLE) begin
      if (i_start) o_win_valid <= 1'b0;
    end else if (win_load) begin
      o_win_valid <= 1'b1;
      o_win_col   <= col - KM1;
      o_win_row   <= row - KM1;
    end else if (consume) begin
      o_win_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_sched.sv
// Randomized bench for conv_window_sched: a pixel-index model predicts ready, window
// timing/coords and done; consumed windows are matched to a raster-order list.
module tb_conv_window_sched;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int K  = 3;
  localparam int CW = 5;
  localparam int NWIN = (W - K + 1) * (H - K + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, pv = 1'b0, wr = 1'b0;
  logic pix_ready, lb_en, win_valid, busy, frame_done;
  logic [CW-1:0] win_col, win_row;

  logic start3 = 1'b0, pv3 = 1'b0, wr3 = 1'b0;
  logic pr3, lb3, wv3, busy3, fd3;
  logic [1:0] wc3, wrow3;

  always #5 clk = ~clk;

  conv_window_sched #(.IMG_W(W), .IMG_H(H), .K(K), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_pix_valid(pv),
    .o_pix_ready(pix_ready), .o_lb_en(lb_en), .o_win_valid(win_valid),
    .i_win_ready(wr), .o_win_col(win_col), .o_win_row(win_row),
    .o_busy(busy), .o_frame_done(frame_done)
  );

  conv_window_sched #(.IMG_W(3), .IMG_H(3), .K(3), .CW(2)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_pix_valid(pv3),
    .o_pix_ready(pr3), .o_lb_en(lb3), .o_win_valid(wv3),
    .i_win_ready(wr3), .o_win_col(wc3), .o_win_row(wrow3),
    .o_busy(busy3), .o_frame_done(fd3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: phase 0 idle / 1 accepting pixels / 2 waiting for the last window to go.
  int  ph, n_acc, pend_c, pend_r;
  bit  pend_v, done_due;
  int  qc[$], qr[$];
  int  n_win, n_done, n_lb, first_lb;
  bit  seen_first;

  task automatic reset_model();
    ph = 0; n_acc = 0; pend_v = 0; done_due = 0;
    qc.delete(); qr.delete();
  endtask

  task automatic step();
    bit exp_ready, acc, cons, drain_ok;
    int c, r;
    @(negedge clk);
    exp_ready = (ph == 1) && (!pend_v || wr);
    acc  = pv && exp_ready;
    cons = pend_v && wr;
    chk("pix_ready", pix_ready, exp_ready);
    chk("lb_en", lb_en, acc);
    chk("win_valid", win_valid, pend_v);
    if (pend_v) begin
      chk("win_col", win_col, pend_c);
      chk("win_row", win_row, pend_r);
    end
    chk("busy", busy, ph != 0);
    chk("frame_done", frame_done, done_due);
    if (win_valid && !seen_first) begin
      seen_first = 1;
      first_lb = n_lb;
    end
    if (frame_done) n_done++;
    if (lb_en) n_lb++;
    done_due = 0;
    if (cons) begin
      n_win++;
      if (qc.size() == 0) chk("extra_window", 1, 0);
      else begin
        chk("seq_col", win_col, qc.pop_front());
        chk("seq_row", win_row, qr.pop_front());
      end
    end
    case (ph)
      0: if (start) begin
        ph = 1; n_acc = 0; pend_v = 0;
        qc.delete(); qr.delete();
        for (int yy = 0; yy <= H - K; yy++)
          for (int xx = 0; xx <= W - K; xx++) begin
            qc.push_back(xx); qr.push_back(yy);
          end
      end
      1: begin
        if (acc) begin
          c = n_acc % W; r = n_acc / W;
          n_acc++;
          if (c >= K - 1 && r >= K - 1) begin
            pend_v = 1; pend_c = c - (K - 1); pend_r = r - (K - 1);
          end else if (cons) pend_v = 0;
          if (n_acc == W * H) ph = 2;
        end else if (cons) pend_v = 0;
      end
      default: begin
        drain_ok = !pend_v || cons;
        if (cons) pend_v = 0;
        if (drain_ok) begin
          done_due = 1; ph = 0;
        end
      end
    endcase
    @(posedge clk); #1;
  endtask

  // mode 0: always valid/ready, 1: random, 2: periodic window stall with pixels offered
  task automatic run_frame(input int mode, input bit noise, input int abort_at, input bit chk_lat);
    int cyc;
    n_win = 0; n_done = 0; n_lb = 0; seen_first = 0; first_lb = 0;
    start = 1; pv = 0; wr = 0;
    step();
    start = 0;
    cyc = 0;
    while (ph != 0 && cyc < 20000) begin
      case (mode)
        0: begin pv = 1; wr = 1; end
        1: begin pv = 1'($urandom % 2); wr = 1'($urandom % 2); end
        default: begin pv = 1; wr = (cyc % 12) >= 5; end
      endcase
      start = noise ? ($urandom % 6 == 0) : 1'b0;
      if (abort_at > 0 && n_acc == abort_at) begin
        start = 0;
        rst = 1;
        #1;
        chk("abort_pix_ready", pix_ready, 0);
        chk("abort_lb_en", lb_en, 0);
        chk("abort_win_valid", win_valid, 0);
        chk("abort_win_col", win_col, 0);
        chk("abort_win_row", win_row, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame_done", frame_done, 0);
        @(posedge clk); #1;
        rst = 0; pv = 1; wr = 1;
        reset_model();
        n_done = 0;
        for (int i = 0; i < 5; i++) step();
        chk("abort_no_done", n_done, 0);
        pv = 0; wr = 0;
        return;
      end
      step();
      cyc++;
    end
    start = 0; pv = 0; wr = 0;
    if (ph != 0) chk("frame_timeout", 0, 1);
    step();
    step();
    chk("win_count", n_win, NWIN);
    chk("acc_count", n_lb, W * H);
    chk("done_count", n_done, 1);
    chk("windows_left", qc.size(), 0);
    if (chk_lat) chk("first_win_latency", first_lb, (K - 1) * W + K);
  endtask

  initial begin
    int a3, w3, d3, f3;
    bit seen3;
    reset_model();
    #3;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_col", win_col, 0);
    chk("rst_win_row", win_row, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    // start together with reset must be ignored
    start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("rst_start_busy", busy, 0);
    rst = 0;
    step(); step();

    run_frame(0, 0, 0, 1);   // streaming frame
    run_frame(2, 0, 0, 0);   // window-side stalls
    run_frame(1, 0, 0, 0);   // random handshakes
    run_frame(1, 1, 0, 0);   // random handshakes plus stray starts
    run_frame(0, 0, 300, 0); // abort mid-frame
    run_frame(0, 0, 0, 1);   // fresh frame after abort

    // 3x3 frame with a 3x3 kernel: a single window
    a3 = 0; w3 = 0; d3 = 0; f3 = -1; seen3 = 0;
    start3 = 1;
    @(posedge clk); #1;
    start3 = 0; pv3 = 1; wr3 = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wv3) begin
        w3++;
        if (!seen3) begin seen3 = 1; f3 = a3; end
        chk("t6_win_col", wc3, 0);
        chk("t6_win_row", wrow3, 0);
      end
      if (lb3) a3++;
      if (fd3) d3++;
      @(posedge clk); #1;
      if (d3 > 0 && !busy3) break;
    end
    pv3 = 0; wr3 = 0;
    chk("t6_first_win_after", f3, 9);
    chk("t6_windows", w3, 1);
    chk("t6_accepts", a3, 9);
    chk("t6_done", d3, 1);
    chk("t6_idle", busy3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
